// File: rtl/im2col_patch_loader_if.sv
// Bus bundle for the im2col patch loader: request inputs, image read port,
// patch buffer write port and status.
interface im2col_patch_loader_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) ();
  logic                  start;
  logic [ADDR_WIDTH-1:0] img_width;
  logic [ADDR_WIDTH-1:0] row;
  logic [ADDR_WIDTH-1:0] col;
  logic [2:0]            k_size;
  logic                  img_rd_en;
  logic [ADDR_WIDTH-1:0] img_addr;
  logic [DATA_WIDTH-1:0] img_data;
  logic                  patch_we;
  logic [ADDR_WIDTH-1:0] patch_waddr;
  logic [DATA_WIDTH-1:0] patch_wdata;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] vec_length;

  // Requester and image memory side
  modport master (
    output start, img_width, row, col, k_size, img_data,
    input  img_rd_en, img_addr, patch_we, patch_waddr, patch_wdata,
           busy, done, vec_length
  );

  // Loader side
  modport slave (
    input  start, img_width, row, col, k_size, img_data,
    output img_rd_en, img_addr, patch_we, patch_waddr, patch_wdata,
           busy, done, vec_length
  );
endinterface

// File: rtl/im2col_patch_loader.sv
// Walks a KxK window of a row-major image, one read per cycle, and copies
// each word into a linear patch buffer in row-major order.
module im2col_patch_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input logic                 clk,
  input logic                 rst,
  im2col_patch_loader_if.slave bus
);
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned KW = 3;
  localparam int unsigned SQW = 2 * KW;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e                state_q;
  logic [AW-1:0]         w_q;
  logic [AW-1:0]         line_q;
  logic [AW-1:0]         cnt_q;
  logic [AW-1:0]         addr_q;
  logic [AW-1:0]         waddr_q;
  logic [AW-1:0]         vlen_q;
  logic [KW-1:0]         k_q;
  logic [KW-1:0]         j_q;
  logic                  rd_q;
  logic                  we_q;
  logic                  busy_q;
  logic                  done_q;

  logic [AW-1:0]         base_d;
  logic [SQW-1:0]        ksq_d;
  logic                  last_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  assign base_d  = bus.row * bus.img_width + bus.col;
  assign ksq_d   = SQW'(bus.k_size) * SQW'(bus.k_size);
  assign last_c  = (cnt_q == vlen_q - AW'(1));
  assign wdata_c = bus.img_data;

  // line_q tracks the address of column 0 of the current window row
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      vlen_q  <= '0;
      k_q     <= '0;
      j_q     <= '0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      we_q    <= rd_q;
      waddr_q <= cnt_q;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && (bus.k_size != '0)) begin
            state_q <= READ;
            busy_q  <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= base_d;
            line_q  <= base_d;
            w_q     <= bus.img_width;
            k_q     <= bus.k_size;
            j_q     <= '0;
            cnt_q   <= '0;
            vlen_q  <= AW'(ksq_d);
          end
        end
        READ: begin
          if (last_c) begin
            state_q <= DRAIN;
            rd_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
            if (j_q == k_q - KW'(1)) begin
              j_q    <= '0;
              line_q <= line_q + w_q;
              addr_q <= line_q + w_q;
            end else begin
              j_q    <= j_q + KW'(1);
              addr_q <= addr_q + AW'(1);
            end
          end
        end
        DRAIN: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.img_rd_en   = rd_q;
  assign bus.img_addr    = addr_q;
  assign bus.patch_we    = we_q;
  assign bus.patch_waddr = waddr_q;
  assign bus.patch_wdata = wdata_c;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.vec_length  = vlen_q;
endmodule
